// File: rtl/nibble_bank_arbiter_pkg.sv
// Shared types and constants for the digit-store arbiter: geometry, FSM states, port ids.
package nibble_bank_arbiter_pkg;

  localparam int NIBBLES = 32;
  localparam int AW      = 5;
  localparam int DW      = 4;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;
  typedef enum logic {PORT1 = 1'b0, PORT2 = 1'b1} port_t;

  // Only matters for non-power-of-2 NIBBLES, where some addresses fall off the end.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return int'(a) < NIBBLES;
  endfunction

  function automatic logic is_last(input logic [AW-1:0] a);
    return int'(a) == NIBBLES - 1;
  endfunction

endpackage

// File: rtl/nibble_bank_arbiter_if.sv
// Two 4-bit requester ports, bulk-clear control and the full-bank display view.
interface nibble_bank_arbiter_if;
  import nibble_bank_arbiter_pkg::*;

  logic                   req1_i, we1_i, gnt1_o, rvalid1_o;
  logic [AW-1:0]          addr1_i;
  logic [DW-1:0]          in1, out1;
  logic                   req2_i, we2_i, gnt2_o, rvalid2_o;
  logic [AW-1:0]          addr2_i;
  logic [DW-1:0]          in2, out2;
  logic                   clr_i, busy_o;
  logic [NIBBLES*DW-1:0]  bank_o;

  modport master (
    output req1_i, we1_i, addr1_i, in1, req2_i, we2_i, addr2_i, in2, clr_i,
    input  gnt1_o, out1, rvalid1_o, gnt2_o, out2, rvalid2_o, busy_o, bank_o
  );

  modport slave (
    input  req1_i, we1_i, addr1_i, in1, req2_i, we2_i, addr2_i, in2, clr_i,
    output gnt1_o, out1, rvalid1_o, gnt2_o, out2, rvalid2_o, busy_o, bank_o
  );

endinterface

// File: rtl/nibble_bank_arbiter_rr_arb2.sv
// Two-input round-robin grant; a tie goes to whichever port did not win last.
module rr_arb2
  import nibble_bank_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req1,
  input  logic req2,
  output logic gnt1,
  output logic gnt2
);

  port_t last_winner;

  always_comb begin
    gnt1 = 1'b0;
    gnt2 = 1'b0;
    if (en) begin
      if (req1 && req2) begin
        gnt1 = (last_winner == PORT2);
        gnt2 = (last_winner == PORT1);
      end else begin
        gnt1 = req1;
        gnt2 = req2;
      end
    end
  end

  // Reset to PORT2 so port 1 takes the first tie.
  always_ff @(posedge clk) begin
    if (rst)       last_winner <= PORT2;
    else if (gnt1) last_winner <= PORT1;
    else if (gnt2) last_winner <= PORT2;
  end

endmodule

// File: rtl/nibble_bank_arbiter.sv
// 32x4-bit digit store shared by two round-robin ports, one access per cycle, 1-cycle reads.
// A bulk clear walks every entry once and holds off both ports while it runs.
module nibble_bank_arbiter
  import nibble_bank_arbiter_pkg::*;
#(
  parameter logic [DW-1:0] CLR_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  nibble_bank_arbiter_if.slave  bus
);

  state_t                 state, state_nxt;
  logic [AW-1:0]          cnt;
  logic [NIBBLES*DW-1:0]  bank;
  logic [DW-1:0]          rd1, rd2;
  logic                   rv1, rv2;
  logic                   arb_en, busy, gnt1, gnt2;

  rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .en   (arb_en),
    .req1 (bus.req1_i),
    .req2 (bus.req2_i),
    .gnt1 (gnt1),
    .gnt2 (gnt2)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.clr_i) state_nxt = CLEAR;
      CLEAR:   if (is_last(cnt)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A clear request in IDLE steals the cycle, so no grant goes out alongside it.
  always_comb begin
    busy   = (state == CLEAR);
    arb_en = (state == IDLE) && !bus.clr_i && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank <= '0;
      cnt  <= '0;
      rd1  <= '0;
      rd2  <= '0;
      rv1  <= 1'b0;
      rv2  <= 1'b0;
    end else begin
      rv1 <= 1'b0;
      rv2 <= 1'b0;
      if (state == CLEAR) begin
        bank[cnt*DW +: DW] <= CLR_VAL;
        cnt <= is_last(cnt) ? '0 : cnt + 1'b1;
      end
      if (gnt1) begin
        if (bus.we1_i) begin
          if (addr_ok(bus.addr1_i)) bank[bus.addr1_i*DW +: DW] <= bus.in1;
        end else begin
          rd1 <= addr_ok(bus.addr1_i) ? bank[bus.addr1_i*DW +: DW] : '0;
          rv1 <= 1'b1;
        end
      end
      if (gnt2) begin
        if (bus.we2_i) begin
          if (addr_ok(bus.addr2_i)) bank[bus.addr2_i*DW +: DW] <= bus.in2;
        end else begin
          rd2 <= addr_ok(bus.addr2_i) ? bank[bus.addr2_i*DW +: DW] : '0;
          rv2 <= 1'b1;
        end
      end
    end
  end

  assign bus.gnt1_o    = gnt1;
  assign bus.gnt2_o    = gnt2;
  assign bus.out1      = rd1;
  assign bus.out2      = rd2;
  assign bus.rvalid1_o = rv1;
  assign bus.rvalid2_o = rv2;
  assign bus.busy_o    = busy;
  assign bus.bank_o    = bank;

endmodule

// File: doc/nibble_bank_arbiter.md
Name: nibble_bank_arbiter

Overview:
- Owns the 128-bit digit store of the clock design: 32 nibbles of 4 bits, one BCD digit or flag each.
- Shares the store between two requesters (port 1: timekeeping counter; port 2: set/adjust logic), each with a 4-bit data path.
- Round-robin arbitration with one access per cycle.
- Sequenced bulk-clear engine.
- Exposes the whole bank for the display scanner.

Parameters:
- NIBBLES, 32, number of 4-bit entries (NIBBLES*DW = 128 at default)
- AW, 5, address width (ceil log2 NIBBLES)
- DW, 4, entry width
- CLR_VAL, 4'h0, value written by bulk clear

Ports:
- clk      in   1        system clock, all logic on rising edge
- rst      in   1        synchronous, active-high reset
- req1_i   in   1        port 1 access request, level, held until granted
- we1_i    in   1        port 1 write enable (0 = read)
- addr1_i  in   AW       port 1 nibble address
- in1      in   DW       port 1 write data
- gnt1_o   out  1        port 1 grant, combinational, same cycle as accepted request
- out1     out  DW       port 1 read data, registered
- rvalid1_o out 1        port 1 read data valid, one-cycle pulse
- req2_i, we2_i, addr2_i, in2, gnt2_o, out2, rvalid2_o: same as port 1, for port 2
- clr_i    in   1        bulk-clear request, single-cycle pulse
- busy_o   out  1        high while bulk clear runs
- bank_o   out  NIBBLES*DW  full bank contents, registered; nibble k = bits [k*DW +: DW]

Behaviour:
- Reset, synchronous on rst=1 at clk edge:
  - all bank bits 0; state IDLE; last_winner = port 2, so port 1 wins the first tie.
  - out1/out2 = 0; rvalid1_o/rvalid2_o = 0; busy_o = 0; clear counter = 0.
  - Reset mid-clear aborts the clear; reset value wins.
- gnt outputs: gnt1_o/gnt2_o are 0 whenever state != IDLE or rst = 1.
- FSM states: IDLE, CLEAR.
- IDLE arbitration:
  - Only req1 → gnt1. Only req2 → gnt2.
  - Both → grant the port that is not last_winner.
  - last_winner updates on every grant.
- Access is performed at the edge ending the grant cycle N:
  - Write: bank[addr] <= in.
  - Read: out <= bank[addr] and rvalid = 1 during cycle N+1.
  - Read latency is 1 cycle.
  - out holds its value until the next read on that port; rvalid is a 1-cycle pulse.
- A requester that keeps req high after its grant is treated as issuing a new request.
- Back-to-back grants to one port are allowed only when the other port is idle.
- Port 2 reads the pre-write value if port 1 wrote the same address in the previous cycle? No: accesses are serialised, so a read in cycle N+1 returns the value written in cycle N.
- Address >= NIBBLES (non-power-of-2 configs only): write is dropped, read returns 0 with rvalid still pulsed.
- clr_i in IDLE:
  - Transition to CLEAR at the next edge; busy_o = 1 from cycle N+1.
  - clr_i has priority over requests in the same cycle; no grant is given in that cycle.
- CLEAR:
  - Each cycle writes CLR_VAL to bank[cnt], then cnt increments.
  - After writing index NIBBLES-1: return to IDLE, cnt = 0, busy_o = 0.
  - Total NIBBLES cycles in CLEAR.
  - clr_i during CLEAR is ignored, with no restart.
  - Requests are held off (no grant) and are served in IDLE afterwards.
- bank_o reflects each write from the cycle after the write edge.

Decomposition:
- Shared package clock_pkg holds:
  - state enum (IDLE, CLEAR);
  - constants NIBBLES, DW, AW;
  - a port-select constant used for last_winner.
- Natural sub-module: rr_arb2, the two-input round-robin grant with a last_winner register.
- Storage, FSM and read registers stay in the top level.

Test Plan:
- Reset then port 1 writes addr 3 = 4'h7; port 2 reads addr 3 next cycle → gnt2 in that cycle; out2 = 4'h7 with rvalid2_o pulse one cycle later; bank_o[15:12] = 4'h7.
- Both ports request every cycle for 6 cycles → grants alternate 1,2,1,2,1,2; never both high; first grant goes to port 1.
- Fill all 32 nibbles with their index mod 16, then pulse clr_i → busy_o high exactly 32 cycles; bank_o = 128'h0 afterwards; pending req1 granted in the first IDLE cycle.
- clr_i pulsed again at clear cycle 10 → ignored; busy_o still ends after 32 total cycles.
- Assert rst at clear cycle 5 → next cycle: state IDLE, busy_o 0, bank_o all 0, out1/out2 0, no rvalid.
- clr_i and req1 (write addr 0 = 4'h9) in the same cycle → no gnt1 that cycle; clear runs; write applied after the clear so bank[0] = 4'h9.
